// File: rtl/draw_phase_scheduler.sv
// Frame-based round-robin scheduler that grants NUM_CH sprite controllers the shared
// VGA write path one DRAW slot at a time, with watchdog, overrun and game-over handling.
module draw_phase_scheduler #(
  parameter int  NUM_CH      = 2,
  parameter int  FRAME_W     = 16,
  parameter int  WDOG_CYCLES = 20000,
  localparam int CH_W        = (NUM_CH > 2) ? $clog2(NUM_CH) : 1
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic               frame_tick,
  input  logic               collision,
  input  logic [NUM_CH-1:0]  req,
  input  logic [NUM_CH-1:0]  done,
  output logic [NUM_CH-1:0]  grant,
  output logic [CH_W-1:0]    active_ch,
  output logic               busy,
  output logic               game_over,
  output logic               frame_overrun,
  output logic               wdog_error,
  output logic [FRAME_W-1:0] frame_count
);

  localparam int WD_W = $clog2(WDOG_CYCLES);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_FRAME,
    ST_ARB,
    ST_DRAW,
    ST_GAME_OVER
  } state_e;

  state_e             state_q,    state_d;
  logic [NUM_CH-1:0]  grant_q,    grant_d;
  logic [CH_W-1:0]    active_q,   active_d;
  logic               overrun_q,  overrun_d;
  logic               wdog_err_q, wdog_err_d;
  logic [FRAME_W-1:0] fc_q,       fc_d;
  logic [NUM_CH-1:0]  pending_q,  pending_d;
  logic [CH_W-1:0]    rr_q,       rr_d;
  logic               coll_q,     coll_d;
  logic [WD_W-1:0]    wdog_cnt_q, wdog_cnt_d;

  logic               pick_valid;
  logic [CH_W-1:0]    pick_idx;
  logic [CH_W-1:0]    cand;
  logic [CH_W-1:0]    rr_next;
  logic               wdog_expired;

  // Search from the highest offset down so the channel closest to rr_q wins last.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int off = NUM_CH - 1; off >= 0; off--) begin
      cand = CH_W'((int'(rr_q) + off) % NUM_CH);
      if (pending_q[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign rr_next      = (rr_q == CH_W'(NUM_CH - 1)) ? '0 : rr_q + 1'b1;
  assign wdog_expired = (wdog_cnt_q == WD_W'(WDOG_CYCLES - 1));

  always_comb begin
    // NOTE: every next-state value gets a hold default up front, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_d    = state_q;
    grant_d    = grant_q;
    active_d   = active_q;
    overrun_d  = overrun_q;
    wdog_err_d = wdog_err_q;
    fc_d       = fc_q;
    pending_d  = pending_q;
    rr_d       = rr_q;
    coll_d     = coll_q;
    wdog_cnt_d = wdog_cnt_q;

    if ((state_q == ST_WAIT_FRAME || state_q == ST_ARB || state_q == ST_DRAW) && collision)
      coll_d = 1'b1;
    // A tick that lands mid-frame is lost, not queued.
    if ((state_q == ST_ARB || state_q == ST_DRAW) && frame_tick)
      overrun_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_WAIT_FRAME;
      end

      ST_WAIT_FRAME: begin
        if (coll_q) begin
          state_d = ST_GAME_OVER;
        end else if (frame_tick) begin
          if (req == '0) begin
            fc_d = fc_q + 1'b1;
          end else begin
            pending_d = req;
            state_d   = ST_ARB;
          end
        end
      end

      ST_ARB: begin
        grant_d = '0;
        if (coll_q) begin
          state_d = ST_GAME_OVER;
        end else if (!pick_valid) begin
          fc_d    = fc_q + 1'b1;
          rr_d    = rr_next;
          state_d = ST_WAIT_FRAME;
        end else begin
          grant_d[pick_idx] = 1'b1;
          active_d          = pick_idx;
          wdog_cnt_d        = '0;
          state_d           = ST_DRAW;
        end
      end

      ST_DRAW: begin
        if (done[active_q]) begin
          pending_d[active_q] = 1'b0;
          grant_d             = '0;
          state_d             = ST_ARB;
        end else if (wdog_expired) begin
          wdog_err_d          = 1'b1;
          pending_d[active_q] = 1'b0;
          grant_d             = '0;
          state_d             = ST_ARB;
        end else begin
          wdog_cnt_d = wdog_cnt_q + 1'b1;
        end
      end

      ST_GAME_OVER: begin
        grant_d = '0;
        if (start) begin
          coll_d     = 1'b0;
          overrun_d  = 1'b0;
          wdog_err_d = 1'b0;
          fc_d       = '0;
          pending_d  = '0;
          rr_d       = '0;
          state_d    = ST_WAIT_FRAME;
        end
      end

      default: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      active_q   <= '0;
      overrun_q  <= 1'b0;
      wdog_err_q <= 1'b0;
      fc_q       <= '0;
      pending_q  <= '0;
      rr_q       <= '0;
      coll_q     <= 1'b0;
      wdog_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      state_q    <= state_d;
      grant_q    <= grant_d;
      active_q   <= active_d;
      overrun_q  <= overrun_d;
      wdog_err_q <= wdog_err_d;
      fc_q       <= fc_d;
      pending_q  <= pending_d;
      rr_q       <= rr_d;
      coll_q     <= coll_d;
      wdog_cnt_q <= wdog_cnt_d;
    end
  end

  assign grant         = grant_q;
  assign active_ch     = active_q;
  assign busy          = (state_q == ST_ARB) || (state_q == ST_DRAW);
  assign game_over     = (state_q == ST_GAME_OVER);
  assign frame_overrun = overrun_q;
  assign wdog_error    = wdog_err_q;
  assign frame_count   = fc_q;

`ifndef SYNTHESIS
  a_grant_onehot0: assert property (@(posedge clk) disable iff (!resetn) $onehot0(grant_q));
  a_grant_only_in_draw: assert property (@(posedge clk) disable iff (!resetn)
    (state_q != ST_DRAW) |-> (grant_q == '0));
`endif

endmodule

// File: tb/tb_draw_phase_scheduler.sv
// Directed bench for draw_phase_scheduler: a 2-channel instance (FRAME_W=2, WDOG=8)
// driven from a vector table plus corner sequences, and a 4-channel instance.
module tb_draw_phase_scheduler;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  logic       a_start, a_tick, a_coll;
  logic [1:0] a_req, a_done, a_grant, a_fc;
  logic       a_active, a_busy, a_go, a_ovr, a_wdog;
  logic [3:0] a_flags;
  assign a_flags = {a_busy, a_go, a_ovr, a_wdog};

  draw_phase_scheduler #(.NUM_CH(2), .FRAME_W(2), .WDOG_CYCLES(8)) dut_a (
    .clk(clk), .resetn(resetn), .start(a_start), .frame_tick(a_tick),
    .collision(a_coll), .req(a_req), .done(a_done), .grant(a_grant),
    .active_ch(a_active), .busy(a_busy), .game_over(a_go),
    .frame_overrun(a_ovr), .wdog_error(a_wdog), .frame_count(a_fc)
  );

  logic        b_start, b_tick, b_coll;
  logic [3:0]  b_req, b_done, b_grant;
  logic [1:0]  b_active;
  logic        b_busy, b_go, b_ovr, b_wdog;
  logic [15:0] b_fc;
  logic [3:0]  b_flags;
  assign b_flags = {b_busy, b_go, b_ovr, b_wdog};

  draw_phase_scheduler #(.NUM_CH(4)) dut_b (
    .clk(clk), .resetn(resetn), .start(b_start), .frame_tick(b_tick),
    .collision(b_coll), .req(b_req), .done(b_done), .grant(b_grant),
    .active_ch(b_active), .busy(b_busy), .game_over(b_go),
    .frame_overrun(b_ovr), .wdog_error(b_wdog), .frame_count(b_fc)
  );

  typedef struct {
    logic       start, tick, coll;
    logic [1:0] req, done;
    logic [1:0] grant;
    logic [3:0] flags;  // {busy, game_over, frame_overrun, wdog_error}
    logic [1:0] fc;
  } vec_t;

  vec_t tbl[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   multi_hot = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_idle();
    a_start = 1'b0; a_tick = 1'b0; a_coll = 1'b0; a_req = '0; a_done = '0;
  endtask

  task automatic b_idle();
    b_start = 1'b0; b_tick = 1'b0; b_coll = 1'b0; b_req = '0; b_done = '0;
  endtask

  function automatic vec_t mk(logic s, logic t, logic c, logic [1:0] r, logic [1:0] d,
                              logic [1:0] g, logic [3:0] f, logic [1:0] fc);
    vec_t v;
    v.start = s; v.tick = t; v.coll = c; v.req = r; v.done = d;
    v.grant = g; v.flags = f; v.fc = fc;
    return v;
  endfunction

  always @(negedge clk) begin
    if ($countones(a_grant) > 1 || $countones(b_grant) > 1) multi_hot++;
  end

  logic [3:0] g_or;
  int         held;

  initial begin
    //            st tk co req    done   grant  flags    fc
    tbl.push_back(mk(0, 0, 1, 2'b00, 2'b00, 2'b00, 4'b0000, 2'd0)); // collision in IDLE ignored
    tbl.push_back(mk(0, 1, 0, 2'b11, 2'b00, 2'b00, 4'b0000, 2'd0)); // tick in IDLE ignored
    tbl.push_back(mk(1, 0, 0, 2'b00, 2'b00, 2'b00, 4'b0000, 2'd0)); // -> WAIT_FRAME
    tbl.push_back(mk(0, 0, 0, 2'b00, 2'b00, 2'b00, 4'b0000, 2'd0)); // no stale collision
    tbl.push_back(mk(0, 1, 0, 2'b11, 2'b00, 2'b00, 4'b1000, 2'd0)); // -> ARB
    tbl.push_back(mk(0, 0, 0, 2'b00, 2'b00, 2'b01, 4'b1000, 2'd0)); // ch0 granted
    tbl.push_back(mk(0, 0, 0, 2'b00, 2'b00, 2'b01, 4'b1000, 2'd0));
    tbl.push_back(mk(0, 0, 0, 2'b00, 2'b00, 2'b01, 4'b1000, 2'd0));
    tbl.push_back(mk(0, 0, 0, 2'b00, 2'b00, 2'b01, 4'b1000, 2'd0));
    tbl.push_back(mk(0, 0, 0, 2'b00, 2'b00, 2'b01, 4'b1000, 2'd0));
    tbl.push_back(mk(0, 0, 0, 2'b00, 2'b01, 2'b00, 4'b1000, 2'd0)); // ch0 done
    tbl.push_back(mk(0, 0, 0, 2'b00, 2'b00, 2'b10, 4'b1000, 2'd0)); // ch1 granted
    tbl.push_back(mk(0, 0, 0, 2'b00, 2'b01, 2'b10, 4'b1000, 2'd0)); // stray done ignored
    tbl.push_back(mk(0, 0, 0, 2'b00, 2'b00, 2'b10, 4'b1000, 2'd0));
    tbl.push_back(mk(0, 0, 0, 2'b00, 2'b00, 2'b10, 4'b1000, 2'd0));
    tbl.push_back(mk(0, 0, 0, 2'b00, 2'b00, 2'b10, 4'b1000, 2'd0));
    tbl.push_back(mk(0, 0, 0, 2'b00, 2'b10, 2'b00, 4'b1000, 2'd0)); // ch1 done
    tbl.push_back(mk(0, 0, 0, 2'b00, 2'b00, 2'b00, 4'b0000, 2'd1)); // frame 1 complete
    tbl.push_back(mk(0, 1, 0, 2'b11, 2'b00, 2'b00, 4'b1000, 2'd1)); // frame 2
    tbl.push_back(mk(0, 0, 0, 2'b00, 2'b00, 2'b10, 4'b1000, 2'd1)); // rr rotated: ch1 first
    tbl.push_back(mk(0, 0, 0, 2'b00, 2'b10, 2'b00, 4'b1000, 2'd1));
    tbl.push_back(mk(0, 0, 0, 2'b00, 2'b00, 2'b01, 4'b1000, 2'd1));
    tbl.push_back(mk(0, 0, 0, 2'b00, 2'b01, 2'b00, 4'b1000, 2'd1));
    tbl.push_back(mk(0, 0, 0, 2'b00, 2'b00, 2'b00, 4'b0000, 2'd2)); // frame 2 complete
    tbl.push_back(mk(0, 1, 0, 2'b00, 2'b00, 2'b00, 4'b0000, 2'd3)); // empty ticks
    tbl.push_back(mk(0, 1, 0, 2'b00, 2'b00, 2'b00, 4'b0000, 2'd0)); // wrap, no flag
    tbl.push_back(mk(0, 1, 0, 2'b00, 2'b00, 2'b00, 4'b0000, 2'd1));
    tbl.push_back(mk(0, 1, 0, 2'b00, 2'b00, 2'b00, 4'b0000, 2'd2));
    tbl.push_back(mk(0, 0, 0, 2'b00, 2'b00, 2'b00, 4'b0000, 2'd2));

    resetn = 1'b0;
    a_idle();
    b_idle();
    repeat (2) @(posedge clk);
    #1;
    check("reset a grant", a_grant, 2'b00);
    check("reset a flags", a_flags, 4'b0000);
    check("reset a fc", a_fc, 2'd0);
    check("reset a active", a_active, 1'b0);
    check("reset b fc", b_fc, 16'd0);
    resetn = 1'b1;
    step();

    // Four-channel instance: sparse request set and wrap-around search.
    g_or = '0;
    b_start = 1'b1; step(); b_idle();
    b_tick = 1'b1; b_req = 4'b1010; step(); b_idle();
    check("b arb busy", b_busy, 1'b1);
    step(); g_or |= b_grant;
    check("b f1 grant1", b_grant, 4'b0010);
    check("b f1 active1", b_active, 2'd1);
    b_done = 4'b0001; step(); b_idle(); g_or |= b_grant;
    check("b stray done", b_grant, 4'b0010);
    b_done = 4'b0010; step(); b_idle(); g_or |= b_grant;
    check("b f1 drop1", b_grant, 4'b0000);
    step(); g_or |= b_grant;
    check("b f1 grant2", b_grant, 4'b1000);
    check("b f1 active2", b_active, 2'd3);
    b_done = 4'b1000; step(); b_idle(); g_or |= b_grant;
    step();
    check("b f1 end busy", b_busy, 1'b0);
    check("b f1 fc", b_fc, 16'd1);
    check("b never ch0/ch2", g_or, 4'b1010);
    b_tick = 1'b1; b_req = 4'b0101; step(); b_idle();
    step();
    check("b f2 grant1", b_grant, 4'b0100);
    check("b f2 active1", b_active, 2'd2);
    b_done = 4'b0100; step(); b_idle();
    step();
    check("b f2 grant2", b_grant, 4'b0001);
    b_done = 4'b0001; step(); b_idle();
    step();
    check("b f2 fc", b_fc, 16'd2);
    check("b f2 flags", b_flags, 4'b0000);

    // Two-channel instance: table of per-cycle vectors.
    for (int i = 0; i < tbl.size(); i++) begin
      a_start = tbl[i].start; a_tick = tbl[i].tick; a_coll = tbl[i].coll;
      a_req = tbl[i].req; a_done = tbl[i].done;
      step();
      check($sformatf("vec%0d grant", i), a_grant, tbl[i].grant);
      check($sformatf("vec%0d flags", i), a_flags, tbl[i].flags);
      check($sformatf("vec%0d fc", i), a_fc, tbl[i].fc);
    end
    a_idle();

    // Watchdog: ch0 never answers, grant must drop after 8 cycles.
    a_tick = 1'b1; a_req = 2'b11; step(); a_idle();
    for (int k = 0; k < 4 && a_grant == 2'b00; k++) step();
    check("wd first grant", a_grant, 2'b01);
    held = 0;
    while (a_grant == 2'b01 && held < 20) begin
      held++;
      step();
    end
    check("wd hold cycles", held, 8);
    check("wd grant dropped", a_grant, 2'b00);
    check("wd flags", a_flags, 4'b1001);
    step();
    check("wd next channel", a_grant, 2'b10);
    a_done = 2'b10; step(); a_idle();
    step();
    check("wd frame end fc", a_fc, 2'd3);

    // Tick during DRAW is dropped and flags overrun; tick+done together.
    a_tick = 1'b1; a_req = 2'b01; step(); a_idle();
    step();
    check("ovr wrap grant", a_grant, 2'b01);
    a_tick = 1'b1; a_req = 2'b11; step(); a_idle();
    check("ovr flag", a_ovr, 1'b1);
    check("ovr grant held", a_grant, 2'b01);
    a_tick = 1'b1; a_done = 2'b01; step(); a_idle();
    check("ovr tick+done grant", a_grant, 2'b00);
    check("ovr tick+done flags", a_flags, 4'b1011);
    step();
    check("ovr frame fc wrap", a_fc, 2'd0);
    step();
    check("ovr no extra frame", a_flags, 4'b0011);

    // Collision mid-DRAW: draw completes, then GAME_OVER.
    a_tick = 1'b1; step(); a_idle();
    check("go pre fc", a_fc, 2'd1);
    a_tick = 1'b1; a_req = 2'b11; step(); a_idle();
    step();
    check("go draw ch0", a_grant, 2'b01);
    a_coll = 1'b1; step(); a_idle();
    check("go draw continues", a_grant, 2'b01);
    check("go not yet", a_go, 1'b0);
    step();
    check("go still drawing", a_grant, 2'b01);
    a_done = 2'b01; step(); a_idle();
    check("go done drop", a_grant, 2'b00);
    step();
    check("go state flags", a_flags, 4'b0111);
    check("go grant zero", a_grant, 2'b00);
    a_tick = 1'b1; step(); a_idle();
    check("go tick ignored", a_flags, 4'b0111);
    a_start = 1'b1; step(); a_idle();
    check("go restart flags", a_flags, 4'b0000);
    check("go restart fc", a_fc, 2'd0);

    // Collision in WAIT_FRAME reaches GAME_OVER one cycle after it is latched.
    a_coll = 1'b1; step(); a_idle();
    check("wait coll latched", a_go, 1'b0);
    step();
    check("wait coll game_over", a_go, 1'b1);
    a_start = 1'b1; step(); a_idle();
    check("wait coll restart", a_go, 1'b0);

    // Asynchronous reset in the middle of a DRAW.
    a_tick = 1'b1; step(); a_idle();
    a_tick = 1'b1; a_req = 2'b10; step(); a_idle();
    step();
    check("rst pre grant", a_grant, 2'b10);
    check("rst pre active", a_active, 1'b1);
    a_tick = 1'b1; step(); a_idle();
    check("rst pre flags", a_flags, 4'b1010);
    #3;
    resetn = 1'b0;
    #1;
    check("rst async grant", a_grant, 2'b00);
    check("rst async active", a_active, 1'b0);
    check("rst async flags", a_flags, 4'b0000);
    check("rst async fc", a_fc, 2'd0);
    check("rst async b fc", b_fc, 16'd0);
    step();
    resetn = 1'b1;
    step();

    check("grant never multi-hot", multi_hot, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
